// File: rtl/key_cmd_sched_if.sv
// Key-event command bus: debounced key pulses in, queued commands out over
// a valid/ready handshake, plus pending-queue status and a drop indication.
interface key_cmd_sched_if #(
    parameter int N    = 4,
    parameter int ID_W = 2
) ();
    logic [N-1:0]    key_pulse;
    logic            cmd_valid;
    logic [ID_W-1:0] cmd_id;
    logic            cmd_ready;
    logic [N-1:0]    pending;
    logic            ovf_pulse;

    // Scheduler side
    modport master (
        input  key_pulse,
        input  cmd_ready,
        output cmd_valid,
        output cmd_id,
        output pending,
        output ovf_pulse
    );

    // Debouncer / command-consumer side
    modport slave (
        output key_pulse,
        output cmd_ready,
        input  cmd_valid,
        input  cmd_id,
        input  pending,
        input  ovf_pulse
    );
endinterface

// File: rtl/key_cmd_sched.sv
// Key command scheduler: queues one pending event per key, issues them one
// at a time with round-robin arbitration, and enforces a holdoff gap after
// every accepted command. All outputs come straight from registers.
module key_cmd_sched #(
    parameter int N       = 4,
    parameter int ID_W    = 2,
    parameter int GAP_CYC = 24000,
    parameter int GAP_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    key_cmd_sched_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    // Counter runs GAP_LOAD..0, so GAP lasts exactly GAP_CYC cycles.
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N - 1);

    state_t          state_reg, state_next;
    logic [N-1:0]    pending_reg, pending_next;
    logic            cmd_valid_reg, cmd_valid_next;
    logic [ID_W-1:0] cmd_id_reg, cmd_id_next;
    logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic            ovf_reg, ovf_next;

    logic            accept;
    logic [N-1:0]    accept_vec;
    logic [N-1:0]    drop_vec;
    logic [N-1:0]    hit_hi;
    logic [ID_W-1:0] sel_hi, sel_lo, sel;
    logic [ID_W-1:0] rr_inc;

    // cmd_valid_reg guards the handshake so cmd_ready is ignored while idle.
    assign accept = cmd_valid_reg & bus.cmd_ready;

    // Per-key queue bookkeeping; a new pulse always wins over the clear so a
    // press coinciding with its own accept is queued again, not dropped.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_key
            localparam logic [ID_W-1:0] IDX = ID_W'(gi);
            assign accept_vec[gi]   = accept && (cmd_id_reg == IDX);
            assign pending_next[gi] = bus.key_pulse[gi] | (pending_reg[gi] & ~accept_vec[gi]);
            assign drop_vec[gi]     = bus.key_pulse[gi] & pending_reg[gi] & ~accept_vec[gi];
            assign hit_hi[gi]       = pending_reg[gi] && (IDX >= rr_ptr_reg);
        end
    endgenerate

    assign ovf_next = |drop_vec;

    // Round-robin pick: lowest pending key at or above rr_ptr, else wrap to
    // the lowest pending key overall.
    always_comb begin
        sel_hi = '0;
        sel_lo = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit_hi[i]) begin
                sel_hi = ID_W'(i);
            end
            if (pending_reg[i]) begin
                sel_lo = ID_W'(i);
            end
        end
        sel = (|hit_hi) ? sel_hi : sel_lo;
    end

    assign rr_inc = (cmd_id_reg == LAST_ID) ? '0 : cmd_id_reg + 1'b1;

    // Next-state logic: selection is frozen from ISSUE entry until accept.
    always_comb begin
        state_next     = state_reg;
        cmd_valid_next = cmd_valid_reg;
        cmd_id_next    = cmd_id_reg;
        rr_ptr_next    = rr_ptr_reg;
        gap_cnt_next   = gap_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|pending_reg) begin
                    cmd_valid_next = 1'b1;
                    cmd_id_next    = sel;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    cmd_valid_next = 1'b0;
                    rr_ptr_next    = rr_inc;
                    if (GAP_CYC > 0) begin
                        gap_cnt_next = GAP_LOAD;
                        state_next   = GAP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next     = IDLE;
                cmd_valid_next = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_id_reg    <= '0;
            rr_ptr_reg    <= '0;
            gap_cnt_reg   <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_id_reg    <= cmd_id_next;
            rr_ptr_reg    <= rr_ptr_next;
            gap_cnt_reg   <= gap_cnt_next;
            ovf_reg       <= ovf_next;
        end
    end

    assign bus.cmd_valid = cmd_valid_reg;
    assign bus.cmd_id    = cmd_id_reg;
    assign bus.pending   = pending_reg;
    assign bus.ovf_pulse = ovf_reg;

endmodule

// File: tb/tb_key_cmd_sched.sv
// Directed bench for key_cmd_sched with N=4, GAP_CYC=3.
module tb_key_cmd_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    key_cmd_sched_if #(.N(4), .ID_W(2)) bus ();

    key_cmd_sched #(
        .N(4), .ID_W(2), .GAP_CYC(3), .GAP_W(20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int got_ids[$];
    int got_gaps[$];
    int first_low;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.key_pulse = '0;
        bus.cmd_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Record issued ids and the low-cycle runs between them.
    task automatic collect(input int cycles);
        bit prev_v;
        int low;
        got_ids.delete();
        got_gaps.delete();
        first_low = -1;
        prev_v = 1'b0;
        low = 0;
        for (int c = 0; c < cycles; c++) begin
            step();
            if (bus.cmd_valid && !prev_v) begin
                if (got_ids.size() == 0) first_low = low;
                else got_gaps.push_back(low);
                got_ids.push_back(int'(bus.cmd_id));
                low = 0;
            end else if (!bus.cmd_valid) begin
                low++;
            end
            prev_v = bus.cmd_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_pulse = 4'b1111;
        bus.cmd_ready = 1'b1;
        step();
        step();
        total++;
        if ({bus.cmd_valid, bus.cmd_id, bus.pending, bus.ovf_pulse} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b id=%0d pend=%b ovf=%b want all 0",
                     bus.cmd_valid, bus.cmd_id, bus.pending, bus.ovf_pulse);
        end
        bus.key_pulse = '0;
        rst_n = 1'b1;
        step();
        $display("reset: valid=%b pending=%b", bus.cmd_valid, bus.pending);
    endtask

    task automatic test_single();
        do_reset();
        bus.key_pulse = 4'b0100;
        step();
        bus.key_pulse = '0;
        total++;
        if (bus.pending !== 4'b0100 || bus.cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_t1 got pend=%b valid=%b want pend=0100 valid=0", bus.pending, bus.cmd_valid);
        end
        step();
        total++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_id !== 2'd2) begin
            bad++;
            $display("FAIL single_t2 got valid=%b id=%0d want valid=1 id=2", bus.cmd_valid, bus.cmd_id);
        end
        step();
        total++;
        if (bus.pending !== 4'b0000 || bus.cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_accept got pend=%b valid=%b want pend=0000 valid=0", bus.pending, bus.cmd_valid);
        end
        $display("single: key 2 issued, pending=%b", bus.pending);
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.key_pulse = 4'b1011;
        step();
        bus.key_pulse = '0;
        collect(30);
        total++;
        if (got_ids.size() !== 3) begin
            bad++;
            $display("FAIL simul_count got=%0d want=3", got_ids.size());
        end else begin
            total++;
            if (got_ids[0] !== 0 || got_ids[1] !== 1 || got_ids[2] !== 3) begin
                bad++;
                $display("FAIL simul_order got=%0d,%0d,%0d want=0,1,3", got_ids[0], got_ids[1], got_ids[2]);
            end
            total++;
            if (got_gaps.size() !== 2 || got_gaps[0] !== 4 || got_gaps[1] !== 4) begin
                bad++;
                $display("FAIL simul_gap got n=%0d want two gaps of 4 low cycles", got_gaps.size());
            end
        end
        // rr_ptr should be back at 0: keys 0 and 3 together must issue 0 first.
        bus.key_pulse = 4'b1001;
        step();
        bus.key_pulse = '0;
        collect(20);
        total++;
        if (got_ids.size() !== 2 || got_ids[0] !== 0 || got_ids[1] !== 3) begin
            bad++;
            $display("FAIL simul_rr_wrap got n=%0d first=%0d want 0 then 3",
                     got_ids.size(), (got_ids.size() > 0) ? got_ids[0] : -1);
        end
        $display("simultaneous: issued %0d commands after wrap check", got_ids.size());
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.key_pulse = 4'b0010;
        step();
        bus.key_pulse = '0;
        collect(12);
        total++;
        if (got_ids.size() !== 1 || got_ids[0] !== 1) begin
            bad++;
            $display("FAIL rr_first got n=%0d want single id 1", got_ids.size());
        end
        bus.key_pulse = 4'b1001;
        step();
        bus.key_pulse = '0;
        collect(20);
        total++;
        if (got_ids.size() !== 2 || got_ids[0] !== 3 || got_ids[1] !== 0) begin
            bad++;
            $display("FAIL rr_order got n=%0d first=%0d want 3 then 0",
                     got_ids.size(), (got_ids.size() > 0) ? got_ids[0] : -1);
        end
        $display("round_robin: after id 1, keys {0,3} issued in %0d commands", got_ids.size());
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.cmd_ready = 1'b0;
        bus.key_pulse = 4'b0010;
        step();
        bus.key_pulse = '0;
        step();
        for (int c = 0; c < 10; c++) begin
            bus.key_pulse = (c == 3) ? 4'b0100 : 4'b0000;
            total++;
            if (bus.cmd_valid !== 1'b1 || bus.cmd_id !== 2'd1) begin
                bad++;
                $display("FAIL bp_hold c=%0d got valid=%b id=%0d want valid=1 id=1", c, bus.cmd_valid, bus.cmd_id);
            end
            step();
        end
        bus.key_pulse = '0;
        total++;
        if (bus.pending !== 4'b0110) begin
            bad++;
            $display("FAIL bp_pending got=%b want=0110", bus.pending);
        end
        bus.cmd_ready = 1'b1;
        step();
        total++;
        if (bus.cmd_valid !== 1'b0 || bus.pending !== 4'b0100) begin
            bad++;
            $display("FAIL bp_accept got valid=%b pend=%b want valid=0 pend=0100", bus.cmd_valid, bus.pending);
        end
        collect(12);
        total++;
        if (got_ids.size() !== 1 || got_ids[0] !== 2 || first_low !== 3) begin
            bad++;
            $display("FAIL bp_next got n=%0d low=%0d want id 2 after 3 more low cycles", got_ids.size(), first_low);
        end
        $display("backpressure: id 1 held, then id 2 issued");
    endtask

    task automatic test_overflow();
        do_reset();
        bus.cmd_ready = 1'b0;
        bus.key_pulse = 4'b0001;
        step();
        bus.key_pulse = '0;
        step();
        bus.key_pulse = 4'b0001;
        step();
        bus.key_pulse = '0;
        total++;
        if (bus.ovf_pulse !== 1'b1 || bus.pending !== 4'b0001) begin
            bad++;
            $display("FAIL ovf_set got ovf=%b pend=%b want ovf=1 pend=0001", bus.ovf_pulse, bus.pending);
        end
        step();
        total++;
        if (bus.ovf_pulse !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%b want=0", bus.ovf_pulse);
        end
        bus.key_pulse = 4'b0010;
        step();
        bus.key_pulse = '0;
        total++;
        if (bus.ovf_pulse !== 1'b0 || bus.pending !== 4'b0011) begin
            bad++;
            $display("FAIL ovf_fresh_key got ovf=%b pend=%b want ovf=0 pend=0011", bus.ovf_pulse, bus.pending);
        end
        bus.key_pulse = 4'b0011;
        step();
        bus.key_pulse = '0;
        total++;
        if (bus.ovf_pulse !== 1'b1) begin
            bad++;
            $display("FAIL ovf_multi got=%b want=1", bus.ovf_pulse);
        end
        step();
        total++;
        if (bus.ovf_pulse !== 1'b0 || bus.cmd_id !== 2'd0) begin
            bad++;
            $display("FAIL ovf_single_pulse got ovf=%b id=%0d want ovf=0 id=0", bus.ovf_pulse, bus.cmd_id);
        end
        $display("overflow: drops flagged, pending=%b", bus.pending);
    endtask

    task automatic test_collision();
        do_reset();
        bus.cmd_ready = 1'b0;
        bus.key_pulse = 4'b0001;
        step();
        bus.key_pulse = '0;
        step();
        bus.cmd_ready = 1'b1;
        bus.key_pulse = 4'b0001;
        step();
        bus.key_pulse = '0;
        total++;
        if (bus.pending !== 4'b0001 || bus.cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL coll_pending got pend=%b valid=%b want pend=0001 valid=0", bus.pending, bus.cmd_valid);
        end
        step();
        total++;
        if (bus.ovf_pulse !== 1'b0) begin
            bad++;
            $display("FAIL coll_no_ovf got=%b want=0", bus.ovf_pulse);
        end
        collect(12);
        total++;
        if (got_ids.size() !== 1 || got_ids[0] !== 0 || first_low !== 2) begin
            bad++;
            $display("FAIL coll_reissue got n=%0d low=%0d want id 0 after 2 more low cycles", got_ids.size(), first_low);
        end
        $display("collision: key 0 re-queued and reissued");
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.cmd_ready = 1'b0;
        bus.key_pulse = 4'b0100;
        step();
        bus.key_pulse = '0;
        step();
        rst_n = 1'b0;
        step();
        total++;
        if (bus.cmd_valid !== 1'b0 || bus.pending !== 4'b0000) begin
            bad++;
            $display("FAIL rst_issue got valid=%b pend=%b want 0/0000", bus.cmd_valid, bus.pending);
        end
        rst_n = 1'b1;
        bus.cmd_ready = 1'b1;
        collect(10);
        total++;
        if (got_ids.size() !== 0) begin
            bad++;
            $display("FAIL rst_issue_quiet got n=%0d want=0", got_ids.size());
        end
        bus.key_pulse = 4'b0110;
        step();
        bus.key_pulse = '0;
        step();
        step();
        rst_n = 1'b0;
        step();
        total++;
        if (bus.cmd_valid !== 1'b0 || bus.pending !== 4'b0000) begin
            bad++;
            $display("FAIL rst_gap got valid=%b pend=%b want 0/0000", bus.cmd_valid, bus.pending);
        end
        rst_n = 1'b1;
        collect(10);
        total++;
        if (got_ids.size() !== 0) begin
            bad++;
            $display("FAIL rst_gap_quiet got n=%0d want=0", got_ids.size());
        end
        bus.key_pulse = 4'b1000;
        step();
        bus.key_pulse = '0;
        collect(6);
        total++;
        if (got_ids.size() !== 1 || got_ids[0] !== 3) begin
            bad++;
            $display("FAIL rst_new_press got n=%0d want single id 3", got_ids.size());
        end
        $display("reset_mid: queue flushed, new press issued");
    endtask

    initial begin
        bus.key_pulse = '0;
        bus.cmd_ready = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_cmd_sched.md
# key_cmd_sched

Collects single-cycle debounced key pulses from N keys, queues one pending event per key, and issues them one at a time to a downstream command consumer over a valid/ready handshake. Arbitration is round-robin. A programmable holdoff gap is enforced between consecutive commands. It sits between the key debouncer bank and the mode/control logic (capture trigger, digit-recognition start, display mode), so that simultaneous presses are never lost or merged.

## Interface
- N, 4: number of key inputs (1..16).
- ID_W, 2: width of cmd_id; must satisfy 2^ID_W >= N.
- GAP_CYC, 24000: holdoff cycles after each accepted command (1 ms at 24 MHz); 0 disables the gap.
- GAP_W, 20: holdoff counter width; must hold GAP_CYC.

- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- key_pulse  in  N  one-cycle press pulses from the debouncer, one bit per key.
- cmd_valid  out  1  command available.
- cmd_id  out  ID_W  index of the key being issued; stable while cmd_valid=1.
- cmd_ready  in  1  consumer accepts when cmd_valid & cmd_ready.
- pending  out  N  queued-event flags, one per key.
- ovf_pulse  out  1  one-cycle flag: a press was dropped because its key was already pending.

## Operation
- Reset (rst_n=0 at a clk edge) sets: state=IDLE, pending=0, cmd_valid=0, cmd_id=0, ovf_pulse=0, rr_ptr=0, gap counter=0. Any in-flight command is abandoned and is not re-issued.
- Pending capture, per bit i, at each edge:
  - set if key_pulse[i]=1;
  - clear if the command for i is accepted this cycle and key_pulse[i]=0;
  - if accept and a new pulse for i occur together, pending[i] stays 1, the new press is queued, and there is no overflow.
- Overflow: key_pulse[i]=1 while pending[i]=1 and i is not being accepted this cycle → the press is dropped and ovf_pulse=1 for the next cycle. Multiple dropped keys in the same cycle produce a single pulse.
- FSM states IDLE, ISSUE, GAP:
  - IDLE: if pending≠0, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, … N-1, 0, …). Register cmd_id=sel and cmd_valid=1, then go to ISSUE. Pulses arriving in the same cycle are visible to IDLE only from the next cycle.
  - ISSUE: hold cmd_valid and cmd_id. On cmd_valid & cmd_ready:
    - cmd_valid←0;
    - rr_ptr←(sel+1) mod N;
    - if GAP_CYC>0, load the counter and go to GAP; else go to IDLE.
  - GAP: count GAP_CYC cycles, then go to IDLE. Key pulses are still captured during GAP.
- cmd_ready is ignored when cmd_valid=0. The selection never changes while cmd_valid=1, even if a higher-priority key arrives.

## Timing
- Pulse high in cycle t → pending bit high from t+1 → cmd_valid high from t+2 (state IDLE, empty queue).
- Accept at edge m:
  - cmd_valid is low from m;
  - GAP occupies cycles m..m+GAP_CYC-1;
  - IDLE at m+GAP_CYC;
  - next cmd_valid from m+GAP_CYC+1.
  - So cmd_valid is low for exactly GAP_CYC+1 cycles between back-to-back commands.
- GAP_CYC=0: cmd_valid is low for exactly 1 cycle between commands.
- Each pending bit clears at the accept edge. ovf_pulse appears 1 cycle after the offending pulse.
- All outputs are registered. There is no combinational path from key_pulse or cmd_ready to any output.

## Test plan
All scenarios use N=4, GAP_CYC=3, cmd_ready tied to 1 unless stated otherwise.
- Reset/single press: after reset, all outputs are 0. key_pulse=4'b0100 for one cycle at t → pending=4'b0100 at t+1; cmd_valid=1 with cmd_id=2 at t+2; pending=0 after accept.
- Simultaneous presses: key_pulse=4'b1011 in one cycle → cmd_id sequence 0, 1, 3. Each cmd_valid is separated by 4 low cycles. rr_ptr ends at 0.
- Round-robin fairness: after issuing id 1, press keys 0 and 3 together → order is 3 then 0.
- Backpressure: cmd_ready=0 for 10 cycles while pressing key 2 during that window → cmd_id=1 stays stable, pending=4'b0110. Release cmd_ready → 1 is accepted, then 2 follows after the gap.
- Overflow and accept/pulse collision:
  - Key 0 pending and stalled by cmd_ready=0, then a second pulse on key 0 → ovf_pulse=1 for one cycle, pending unchanged.
  - A key 0 pulse in the same cycle as its accept → pending[0] stays 1, no ovf_pulse, id 0 is issued again after the gap.
- Reset mid-operation: assert rst_n=0 during ISSUE with cmd_valid=1 and during GAP → the next edge shows cmd_valid=0 and pending=0. After release, nothing is issued until a new press arrives.
